fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 91 +++++++++
 tb/tb_fetch_buffer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Fetch-to-decode instruction buffer: a DEPTH-entry circular FIFO of {pc, instr}
// with full back-pressure, flush on redirect and a sticky overflow flag.
module fetch_buffer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enq_valid,
  input  logic [ADDR_W-1:0]          enq_pc,
  input  logic [INSTR_W-1:0]         enq_instr,
  output logic                       pc_write,
  input  logic                       dec_ready,
  output logic                       dec_valid,
  output logic [ADDR_W-1:0]          dec_pc,
  output logic [INSTR_W-1:0]         dec_instr,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);
  localparam logic [INSTR_W-1:0] NOP      = INSTR_W'(32'h0000_0013);

  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ovf_q,    ovf_d;

  logic full, empty, enq_fire, deq_fire;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign pc_write  = ~full;
  assign dec_valid = ~empty;
  assign count     = count_q;
  assign ovf_err   = ovf_q;
  assign dec_pc    = empty ? '0  : pc_mem_q[rd_ptr_q];
  assign dec_instr = empty ? NOP : instr_mem_q[rd_ptr_q];

  assign enq_fire = enq_valid & pc_write  & ~flush;
  assign deq_fire = dec_valid & dec_ready & ~flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (enq_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq_fire) rd_ptr_d = rd_ptr_q + 1'b1;
      if (enq_fire && !deq_fire) count_d = count_q + 1'b1;
      else if (deq_fire && !enq_fire) count_d = count_q - 1'b1;
      if (enq_valid && full) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!reset && enq_fire) begin
      pc_mem_q[wr_ptr_q]    <= enq_pc;
      instr_mem_q[wr_ptr_q] <= enq_instr;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the buffer.
module tb_fetch_buffer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 32;

  logic                    clk = 1'b0;
  logic                    reset, enq_valid, dec_ready, flush;
  logic [ADDR_W-1:0]       enq_pc;
  logic [INSTR_W-1:0]      enq_instr;
  logic                    pc_write, dec_valid, ovf_err;
  logic [ADDR_W-1:0]       dec_pc;
  logic [INSTR_W-1:0]      dec_instr;
  logic [$clog2(DEPTH):0]  count;

  fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .reset(reset), .enq_valid(enq_valid), .enq_pc(enq_pc),
    .enq_instr(enq_instr), .pc_write(pc_write), .dec_ready(dec_ready),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_instr(dec_instr),
    .flush(flush), .count(count), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ins;
  } ent_t;

  ent_t fifo[$];
  logic m_ovf;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int n = fifo.size();
    check("count",     64'(count),     64'(n));
    check("pc_write",  64'(pc_write),  64'(n != DEPTH));
    check("dec_valid", 64'(dec_valid), 64'(n != 0));
    check("dec_pc",    64'(dec_pc),    (n != 0) ? 64'(fifo[0].pc)  : 64'd0);
    check("dec_instr", 64'(dec_instr), (n != 0) ? 64'(fifo[0].ins) : 64'h13);
    check("ovf_err",   64'(ovf_err),   64'(m_ovf));
  endtask

  // Drive one cycle: inputs applied after the previous edge, outputs checked
  // before the next edge, model advanced by the buffer's rules.
  task automatic step(input logic r, input logic f, input logic ev,
                      input logic [ADDR_W-1:0] pc, input logic [INSTR_W-1:0] ins,
                      input logic dr);
    ent_t e;
    bit   full, deq, enq;
    reset = r; flush = f; enq_valid = ev; enq_pc = pc; enq_instr = ins; dec_ready = dr;
    #1;
    if (total > 0 || !r) check_outputs();
    if (r) begin
      fifo.delete();
      m_ovf = 1'b0;
    end else if (f) begin
      fifo.delete();
    end else begin
      full = (fifo.size() == DEPTH);
      deq  = (fifo.size() != 0) && dr;
      enq  = ev && !full;
      if (ev && full) m_ovf = 1'b1;
      if (deq) void'(fifo.pop_front());
      if (enq) begin
        e.pc = pc; e.ins = ins;
        fifo.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_ovf = 1'b0;
    reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; dec_ready = 1'b0;
    enq_pc = '0; enq_instr = '0;
    @(posedge clk); #1;

    // Reset then idle
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_nop",   64'(dec_instr), 64'h13);
    check("rst_pcw",   64'(pc_write), 64'd1);

    // Fill to full, then overflow attempt
    step(0, 0, 1, 8'd0,  32'hAAAA_0001, 0);
    step(0, 0, 1, 8'd4,  32'hBBBB_0002, 0);
    step(0, 0, 1, 8'd8,  32'hCCCC_0003, 0);
    step(0, 0, 1, 8'd12, 32'hDDDD_0004, 0);
    check("full_count", 64'(count), 64'd4);
    check("full_pcw",   64'(pc_write), 64'd0);
    check("full_head",  64'(dec_instr), 64'hAAAA_0001);
    step(0, 0, 1, 8'd16, 32'hEEEE_0005, 0);
    check("ovf_set",    64'(ovf_err), 64'd1);
    check("ovf_count",  64'(count), 64'd4);

    // Drain
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
    check("drain_valid", 64'(dec_valid), 64'd0);

    // Reset to clear ovf, then streaming across wrap
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      step(0, 0, 1, 8'(i * 4), 32'h1000_0000 + 32'(i), 1);
    check("stream_count", 64'(count), 64'd1);
    check("stream_ovf",   64'(ovf_err), 64'd0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 1);

    // count=3 then flush with enqueue
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'(40 + i * 4), 32'h2000_0000 + 32'(i), 0);
    step(0, 1, 1, 8'd99, 32'hDEAD_BEEF, 0);
    check("flush_count", 64'(count), 64'd0);
    check("flush_pcw",   64'(pc_write), 64'd1);
    step(0, 0, 0, 0, 0, 1);

    // Build ovf, count=2, then reset with flush and enqueue
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(i * 4), 32'h3000_0000 + 32'(i), 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 1, 8'd77, 32'h4444_4444, 0);
    check("rst2_count", 64'(count), 64'd0);
    check("rst2_ovf",   64'(ovf_err), 64'd0);
    check("rst2_pc",    64'(dec_pc), 64'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 9) < 7),
           8'($urandom), $urandom,
           ($urandom_range(0, 9) < 5));
    end
    step(0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
